// File: rtl/barrel_shifter.sv
// Log2-stage barrel shifter: LSL / LSR / ASR / ROL by 0..WIDTH-1 positions,
// one result per cycle with a single registered output stage.
module barrel_shifter #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   shifter,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROL = 2'b11
    } mode_e;

    mode_e            mode_sel;
    logic             sign_bit;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] result_reg;
    logic             out_valid_reg;

    assign mode_sel = mode_e'(mode);
    // ASR fills from the operand's original MSB, not the partially shifted word
    assign sign_bit = data[WIDTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < SHW; gi++) begin : g_stage
            localparam int STEP = 1 << gi;

            logic [WIDTH-1:0] stage_in;
            logic [WIDTH-1:0] stage_out;
            logic [WIDTH-1:0] lsl_val;
            logic [WIDTH-1:0] lsr_val;
            logic [WIDTH-1:0] asr_val;
            logic [WIDTH-1:0] rol_val;
            logic [WIDTH-1:0] shifted;

            if (gi == 0) begin : g_first
                assign stage_in = data;
            end else begin : g_chain
                assign stage_in = g_stage[gi-1].stage_out;
            end

            assign lsl_val = {stage_in[WIDTH-1-STEP:0], {STEP{1'b0}}};
            assign lsr_val = {{STEP{1'b0}}, stage_in[WIDTH-1:STEP]};
            assign asr_val = {{STEP{sign_bit}}, stage_in[WIDTH-1:STEP]};
            assign rol_val = {stage_in[WIDTH-1-STEP:0], stage_in[WIDTH-1:WIDTH-STEP]};

            always_comb begin
                shifted = lsl_val;
                case (mode_sel)
                    MODE_LSL: shifted = lsl_val;
                    MODE_LSR: shifted = lsr_val;
                    MODE_ASR: shifted = asr_val;
                    MODE_ROL: shifted = rol_val;
                    default:  shifted = lsl_val;
                endcase
            end

            assign stage_out = shifter[gi] ? shifted : stage_in;
        end
    endgenerate

    assign shift_next = g_stage[SHW-1].stage_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                result_reg <= shift_next;
            end
        end
    end

    assign result    = result_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_barrel_shifter.sv
// Scoreboard bench for barrel_shifter (WIDTH=8): stimulus pushes expected
// results, a negedge monitor pops and compares whenever out_valid is high.
module tb_barrel_shifter;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] data;
    logic [2:0] shifter;
    logic [1:0] mode;
    logic [7:0] result;
    logic       out_valid;

    int         vectors;
    int         miscompares;
    int         txn;
    logic [7:0] exp_q[$];
    logic [7:0] last_exp;

    barrel_shifter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data      (data),
        .shifter   (shifter),
        .mode      (mode),
        .result    (result),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s,
                                             input logic [1:0] m);
        logic [15:0] dd;
        logic [7:0]  r;
        case (m)
            2'b00:   r = d << s;
            2'b01:   r = d >> s;
            2'b10:   r = 8'($signed(d) >>> s);
            default: begin
                dd = {d, d} << s;
                r  = dd[15:8];
            end
        endcase
        return r;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (out_valid) begin
            vectors++;
            txn++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output txn=%0d result=%02h required=no output", txn, result);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (result !== e) begin
                    miscompares++;
                    $display("FAIL result txn=%0d got=%02h required=%02h", txn, result, e);
                end else begin
                    $display("txn %0d: result=%02h expected=%02h ok", txn, result, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s got=%02h required=%02h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m,
                        input logic [7:0] expv);
        rst      = 1'b0;
        in_valid = 1'b1;
        data     = d;
        shifter  = s;
        mode     = m;
        exp_q.push_back(expv);
        last_exp = expv;
        step();
        chk("out_valid_after_send", {7'd0, out_valid}, 8'd1);
    endtask

    task automatic idle();
        rst      = 1'b0;
        in_valid = 1'b0;
        data     = 8'hA5;
        shifter  = 3'd5;
        mode     = 2'b11;
        step();
    endtask

    initial begin
        logic [3:0] wide_amt;
        logic [7:0] rd;
        logic [2:0] rs;
        logic [1:0] rm;

        vectors     = 0;
        miscompares = 0;
        txn         = 0;
        last_exp    = 8'h00;

        // Reset held two cycles with a transfer presented: must be discarded
        rst = 1'b1; in_valid = 1'b1; data = 8'hFF; shifter = 3'd1; mode = 2'b00;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("reset_result", result, 8'h00);
            chk("reset_out_valid", {7'd0, out_valid}, 8'd0);
        end
        for (int i = 0; i < 2; i++) begin
            idle();
            chk("post_reset_result", result, 8'h00);
            chk("post_reset_out_valid", {7'd0, out_valid}, 8'd0);
        end

        // Directed vectors, hand-computed expectations
        send(8'h10, 3'd4, 2'b00, 8'h00);
        send(8'h10, 3'd2, 2'b00, 8'h40);
        send(8'h80, 3'd2, 2'b01, 8'h20);
        send(8'h80, 3'd2, 2'b10, 8'hE0);
        send(8'h80, 3'd2, 2'b00, 8'h00);
        send(8'h81, 3'd1, 2'b11, 8'h03);
        wide_amt = 4'd8;
        for (int m = 0; m < 4; m++) begin
            send(8'h20, wide_amt[2:0], 2'(m), 8'h20);
        end
        send(8'hB4, 3'd3, 2'b11, 8'hA5);
        send(8'h7F, 3'd7, 2'b10, 8'h00);
        send(8'h80, 3'd7, 2'b10, 8'hFF);
        send(8'hFF, 3'd7, 2'b01, 8'h01);
        send(8'hFF, 3'd7, 2'b00, 8'h80);
        send(8'h96, 3'd7, 2'b11, 8'h4B);
        send(8'hC3, 3'd5, 2'b10, 8'hFE);

        // Back-to-back random stream checked against the reference model
        for (int i = 0; i < 5; i++) begin
            rd = 8'($urandom);
            rs = 3'($urandom_range(0, 7));
            rm = 2'($urandom_range(0, 3));
            send(rd, rs, rm, ref_shift(rd, rs, rm));
        end

        // Bubble: out_valid drops, result holds
        idle();
        chk("bubble_out_valid", {7'd0, out_valid}, 8'd0);
        chk("bubble_result_held", result, last_exp);

        // Reset while a transfer is offered
        rst = 1'b1; in_valid = 1'b1; data = 8'hFF; shifter = 3'd3; mode = 2'b01;
        step();
        chk("midstream_reset_result", result, 8'h00);
        chk("midstream_reset_out_valid", {7'd0, out_valid}, 8'd0);

        idle();
        idle();
        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
